comparador_serial_ctrl: RTL and testbench
=========================================

COMPARADOR_SERIAL_CTRL -- requirements
Module: comparador_serial_ctrl

Interface
REQ-001 SHALL provide parameter K, default 5, meaning operand width in bits (K >= 2).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port start  input  1  request to compare the values on a and b.
REQ-005 SHALL provide port a  input  K  operand A, unsigned, MSB at index K-1.
REQ-006 SHALL provide port b  input  K  operand B, unsigned.
REQ-007 SHALL provide port busy  output  1  comparison in progress.
REQ-008 SHALL provide port done  output  1  one-cycle pulse, result valid.
REQ-009 SHALL provide port gt  output  1  A > B.
REQ-010 SHALL provide port lt  output  1  A < B.
REQ-011 SHALL provide port eq  output  1  A == B.
REQ-012 SHALL provide port bit_idx  output  $clog2(K)  index of the bit pair being compared.
REQ-013 SHALL provide port a_bit  output  1  captured A bit at bit_idx, serial trace.
REQ-014 SHALL provide port b_bit  output  1  captured B bit at bit_idx, serial trace.

Function
REQ-015 SHALL implement FSM states IDLE, COMPARE, DONE.
REQ-016 Start acceptance SHALL happen in IDLE or DONE when start=1 at a rising edge; at that edge it latches a and b, clears gt/lt/eq, and sets bit_idx=K-1 and state=COMPARE.
REQ-017 start SHALL be ignored in COMPARE; latched operands SHALL NOT change after acceptance, even if a or b change.
REQ-018 busy SHALL be 1 exactly while state=COMPARE.
REQ-019 a_bit/b_bit SHALL combinationally reflect latched A[bit_idx]/B[bit_idx].
REQ-020 In COMPARE, one bit pair SHALL be evaluated per cycle, MSB first (left to right).
REQ-021 Unequal pair: set gt=a_bit&~b_bit and lt=~a_bit&b_bit, then go to DONE (early exit).
REQ-022 Equal pair with bit_idx=0: set eq=1, then go to DONE.
REQ-023 Equal pair with bit_idx>0: decrement bit_idx and stay in COMPARE; bit_idx SHALL never wrap below 0.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE unless a new start is accepted.
REQ-025 Latency: first differing bit p (K-1..0) SHALL give done high in the (K-p+1)th cycle after the accepting edge; equal operands give done in cycle K+1.
REQ-026 gt, lt, eq SHALL be one-hot once done has pulsed, and SHALL hold their values until the next start acceptance.
REQ-027 bit_idx SHALL hold its last compared value in DONE and IDLE.
REQ-028 start in DONE SHALL be accepted the same way as in IDLE, giving back-to-back operation with no idle cycle.

Reset
REQ-029 rst_n=0 SHALL force state=IDLE, busy=0, done=0, gt=lt=eq=0, bit_idx=0 and latched operands=0 immediately, without waiting for a clock edge.
REQ-030 Reset asserted mid-COMPARE SHALL abort the comparison; no done pulse SHALL follow, and the first start after rst_n=1 SHALL be accepted normally.

Verification
REQ-031 K=5, start with A=10110, B=10011 -> busy for 3 cycles (bit_idx 4,3,2), done in cycle 4, gt=1, lt=0, eq=0.
REQ-032 A=01101, B=01101 -> bit_idx counts 4..0, busy 5 cycles, done in cycle 6, eq=1.
REQ-033 A=00000, B=10000 -> done in cycle 2, lt=1, bit_idx=4 held afterwards.
REQ-034 start held high and a/b changed during COMPARE -> no restart, result matches the originally latched operands; start high during the DONE cycle -> new comparison begins on the next cycle.
REQ-035 rst_n pulsed low while bit_idx=2 -> outputs immediately return to reset values, no done pulse; a subsequent start with A=11111, B=11110 -> done in cycle 6, gt=1.

Source files
------------

// File: rtl/comparador_serial_ctrl.sv
// ---------------------------------------------------------------------------
// comparador_serial_ctrl
//
// Serial magnitude comparator for two unsigned K-bit operands. On an accepted
// start the operands are latched. One bit pair is then compared per clock,
// MSB first. The comparison ends early at the first differing pair, or after
// bit 0 when every pair matched. The result flags are held until the next
// accepted start.
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request a comparison (accepted in IDLE or DONE)
//   a, b     in   K-bit unsigned operands, MSB at index K-1
//   busy     out  high while a comparison is in progress (COMPARE)
//   done     out  one-cycle pulse, result flags valid
//   gt/lt/eq out  A > B / A < B / A == B, one-hot after done
//   bit_idx  out  index of the bit pair under comparison / last compared
//   a_bit    out  latched A[bit_idx] (serial trace)
//   b_bit    out  latched B[bit_idx] (serial trace)
// ---------------------------------------------------------------------------
module comparador_serial_ctrl #(
   parameter int K = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [K-1:0]           a,
   input  logic [K-1:0]           b,
   output logic                   busy,
   output logic                   done,
   output logic                   gt,
   output logic                   lt,
   output logic                   eq,
   output logic [$clog2(K)-1:0]   bit_idx,
   output logic                   a_bit,
   output logic                   b_bit
);

   localparam int IW = $clog2(K);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t         state, state_next;
   logic [K-1:0]   a_q, b_q;
   logic           accept;
   logic           pair_eq;
   logic           last_bit;

   // Serial trace of the pair currently under comparison.
   assign a_bit    = a_q[bit_idx];
   assign b_bit    = b_q[bit_idx];
   assign pair_eq  = (a_bit == b_bit);
   assign last_bit = (bit_idx == '0);

   // A new request is taken in IDLE or DONE. A request in DONE starts the
   // next comparison back-to-back, with no idle cycle in between.
   assign accept = start && ((state == IDLE) || (state == DONE));

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // NOTE: the default assignment at the top keeps this block free of
   // inferred latches on every path through the case statement.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) state_next = COMPARE;
         end
         COMPARE: begin
            // Early exit on the first differing pair; otherwise stop after bit 0.
            if (!pair_eq || last_bit) state_next = DONE;
         end
         DONE: begin
            state_next = start ? COMPARE : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic (Moore)
   // ------------------------------------------------------------------
   always_comb begin
      busy = (state == COMPARE);
      done = (state == DONE);
   end

   // ------------------------------------------------------------------
   // Datapath: latched operands, bit index and result flags
   // ------------------------------------------------------------------
   // NOTE: the operand registers are reset as well as the control state.
   // This makes the a_bit/b_bit trace read zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         bit_idx <= '0;
         gt      <= 1'b0;
         lt      <= 1'b0;
         eq      <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         bit_idx <= IW'(K - 1);
         gt      <= 1'b0;
         lt      <= 1'b0;
         eq      <= 1'b0;
      end else if (state == COMPARE) begin
         if (!pair_eq) begin
            // bit_idx is left at the deciding pair so it stays observable.
            gt <= a_bit & ~b_bit;
            lt <= ~a_bit & b_bit;
         end else if (last_bit) begin
            eq <= 1'b1;
         end else begin
            bit_idx <= bit_idx - IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_comparador_serial_ctrl
//
// Directed-vector scoreboard bench for comparador_serial_ctrl with K=5.
// The stimulus pushes the expected result and the expected done cycle into a
// queue. A monitor pops and compares whenever done is high.
// ---------------------------------------------------------------------------
module tb_comparador_serial_ctrl;

   localparam int K  = 5;
   localparam int IW = $clog2(K);

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [K-1:0]  a;
   logic [K-1:0]  b;
   logic          busy;
   logic          done;
   logic          gt;
   logic          lt;
   logic          eq;
   logic [IW-1:0] bit_idx;
   logic          a_bit;
   logic          b_bit;

   typedef struct {
      logic          gt;
      logic          lt;
      logic          eq;
      logic [IW-1:0] idx;
      int            done_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cycle_cnt = 0;

   comparador_serial_ctrl #(.K(K)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .gt      (gt),
      .lt      (lt),
      .eq      (eq),
      .bit_idx (bit_idx),
      .a_bit   (a_bit),
      .b_bit   (b_bit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cycle_cnt);
      end
   endtask

   // Drive a one-cycle start at the next falling edge. The task returns at the
   // falling edge of the first COMPARE cycle. If push is set, the expected
   // result is queued with its done cycle at latency lat after acceptance.
   task automatic issue(input logic [K-1:0] av, input logic [K-1:0] bv, input bit push,
                        input logic egt, input logic elt, input logic eeq,
                        input logic [IW-1:0] eidx, input int lat);
      exp_t e;
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      if (push) begin
         e.gt = egt; e.lt = elt; e.eq = eeq; e.idx = eidx;
         e.done_cyc = cycle_cnt + lat;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (done !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("done_within_bound", (k < 20), 1);
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            check("done_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("done_cycle", cycle_cnt, e.done_cyc);
               check("res_gt", gt, e.gt);
               check("res_lt", lt, e.lt);
               check("res_eq", eq, e.eq);
               check("res_bit_idx", bit_idx, e.idx);
            end
         end
      end
   end

   initial begin
      logic [K-1:0] av;
      int           n;
      int           k;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;

      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_flags", {gt, lt, eq}, 0);
      check("rst_bit_idx", bit_idx, 0);
      check("rst_trace", {a_bit, b_bit}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // A=10110 B=10011: differs at bit 2, done in cycle 4, gt
      issue(5'b10110, 5'b10011, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 4);
      check("t1_busy_c1", busy, 1);
      check("t1_idx_c1", bit_idx, 4);
      wait_done();
      @(negedge clk);
      check("t1_busy_after", busy, 0);
      check("t1_gt_held", gt, 1);
      check("t1_idx_held", bit_idx, 2);

      // A=01101 B=01101: full scan 4..0, done in cycle 6, eq
      av = 5'b01101;
      issue(av, av, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 6);
      for (int i = K - 1; i >= 0; i--) begin
         check("t2_idx_scan", bit_idx, i);
         check("t2_a_bit", a_bit, av[i]);
         check("t2_busy", busy, 1);
         @(negedge clk);
      end
      wait_done();

      // A=00000 B=10000: differs at MSB, done in cycle 2, lt, bit_idx stays 4
      issue(5'b00000, 5'b10000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 2);
      wait_done();
      @(negedge clk);
      check("t3_lt_held", lt, 1);
      check("t3_idx_held", bit_idx, 4);
      check("t3_idle", {busy, done}, 0);

      // start held high, a/b changed mid-compare. The first result must match
      // the latched 11000 vs 11100 (lt at bit 2). Start is still high in DONE,
      // so 11111 vs 00000 follows back-to-back (gt at bit 4).
      @(negedge clk);
      a     = 5'b11000;
      b     = 5'b11100;
      start = 1'b1;
      n     = cycle_cnt;
      exp_q.push_back('{gt: 1'b0, lt: 1'b1, eq: 1'b0, idx: 3'd2, done_cyc: n + 4});
      exp_q.push_back('{gt: 1'b1, lt: 1'b0, eq: 1'b0, idx: 3'd4, done_cyc: n + 6});
      @(negedge clk);
      a = 5'b11111;
      b = 5'b00000;
      check("t4_busy_c1", busy, 1);
      repeat (3) @(negedge clk);
      check("t4_done_c4", done, 1);
      @(negedge clk);
      start = 1'b0;
      check("t4_back_to_back_busy", busy, 1);
      check("t4_restart_idx", bit_idx, 4);
      wait_done();

      // Reset mid-compare at bit_idx=2: immediate clear, no done afterwards
      issue(5'b01101, 5'b01101, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0);
      @(negedge clk);
      @(negedge clk);
      check("t5_idx_before_rst", bit_idx, 2);
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_flags", {gt, lt, eq}, 0);
      check("t5_rst_idx", bit_idx, 0);
      check("t5_rst_trace", {a_bit, b_bit}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("t5_no_done", done, 0);
      end

      // A=11111 B=11110 after reset: differs at bit 0, done in cycle 6, gt
      issue(5'b11111, 5'b11110, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6);
      wait_done();

      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
